project1_lcd_ctrl: RTL
======================

PROJECT1_LCD_CTRL -- requirements
Module: project1_lcd_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, meaning cycles that RS/data are valid before EN rises.
REQ-002 SHALL have parameter EN_CYC, default 12, meaning EN high width in cycles.
REQ-003 SHALL have parameter HOLD_CYC, default 2, meaning cycles that RS/data are held after EN falls.
REQ-004 SHALL have parameter EXEC_CYC, default 2000, meaning post-write execution wait in cycles.
REQ-005 SHALL have parameter LONG_CYC, default 82000, meaning execution wait for clear/home commands.
REQ-006 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports: address  in  2  register select; chipselect  in  1; write_n  in  1  active-low write strobe; writedata  in  32.
REQ-009 SHALL have ports: readdata  out  32  combinational read mux, zero wait states.
REQ-010 SHALL have ports: lcd_data  out  8; lcd_rs  out  1; lcd_rw  out  1  tied 0; lcd_en  out  1; lcd_on  out  1  panel/backlight enable.

Function
REQ-011 SHALL decode writes (chipselect && !write_n) as follows: addr0 enqueues {RS=0, writedata[7:0]}; addr1 enqueues {RS=1, writedata[7:0]}; addr3 is control (bit0 lcd_on, bit1=1 flush, bit2=1 clear overflow); addr2 writes are ignored.
REQ-012 SHALL return readdata at addr2 as {26'b0, overflow, busy, full, level[2:0]} and at addr3 as {31'b0, lcd_on}, and SHALL return 0 at addr0/1.
REQ-013 SHALL buffer requests in a 4-entry, 9-bit FIFO with level 0..4.
REQ-014 SHALL accept a write iff level<4 or a pop occurs in the same cycle; otherwise the write is dropped, the FIFO is unchanged, and overflow is set sticky.
REQ-015 SHALL apply flush by setting level to 0 on the next edge; flush wins over a same-cycle enqueue, and an in-flight transaction completes unaltered.
REQ-016 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD, WAIT with a single down-counter of width clog2(LONG_CYC+1).
REQ-017 SHALL, in IDLE with level>0, pop the head, register lcd_rs/lcd_data on the same edge, and enter SETUP with count=SETUP_CYC.
REQ-018 SHALL keep lcd_en=0 for SETUP_CYC cycles in SETUP, then enter PULSE.
REQ-019 SHALL keep lcd_en=1 for exactly EN_CYC cycles in PULSE, then enter HOLD.
REQ-020 SHALL keep lcd_en=0 for HOLD_CYC cycles in HOLD, then enter WAIT.
REQ-021 SHALL stay in WAIT for LONG_CYC cycles if RS=0 and byte in {0x01,0x02,0x03}, else for EXEC_CYC cycles, then return to IDLE.
REQ-022 SHALL keep lcd_data/lcd_rs stable from load until the next pop.
REQ-023 SHALL space back-to-back entries by 1+SETUP_CYC+EN_CYC+HOLD_CYC+wait cycles, measured from pop to pop.
REQ-024 SHALL assert busy when state!=IDLE or level>0, and assert full when level==4.
REQ-025 SHALL treat parameters of 0 as 1 cycle.

Reset
REQ-026 SHALL, on reset, drive state=IDLE, level=0, overflow=0, lcd_on=0, lcd_en=0, lcd_rs=0, lcd_data=0x00, and lcd_rw=0.
REQ-027 SHALL, on reset mid-transaction, force lcd_en low at the same edge, with no completion of the pulse.

Structure
REQ-028 SHALL place the FSM state encoding, register address constants, and status bit positions in package project1_lcd_ctrl_pkg.
REQ-029 SHALL implement the FIFO as sub-module project1_lcd_ctrl_fifo (push, pop, flush, level, head), and SHALL keep the FSM and Avalon decode in the top level.

Verification (bench parameters SETUP=2, EN=4, HOLD=2, EXEC=10, LONG=50)
REQ-030 SHALL verify: write addr1 0x41 -> one pop, lcd_rs=1, lcd_data=0x41, lcd_en high exactly 4 cycles starting 3 cycles after pop, busy clears 19 cycles after pop.
REQ-031 SHALL verify: write addr0 0x01 then addr0 0x38 -> second pop 59 cycles after first (1+2+4+2+50).
REQ-032 SHALL verify: 5 back-to-back writes while busy (FIFO empty, FSM in WAIT) -> level=4, full=1, 5th dropped, overflow=1; writing addr3 0x4 clears overflow.
REQ-033 SHALL verify: flush (addr3 0x3) during PULSE with level=3 -> current EN pulse stays 4 cycles, level=0 next cycle, no further EN pulses, lcd_on=1.
REQ-034 SHALL verify: reset asserted during PULSE -> lcd_en=0, state IDLE, all outputs at reset values after that edge; after release, FIFO is empty and no pulse occurs.
REQ-035 SHALL verify: write at full in the same cycle as an IDLE pop -> write accepted, level stays 4, overflow stays 0.

Source files
------------

// File: rtl/project1_lcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : project1_lcd_ctrl_pkg
// Description : Shared types and constants for the HD44780-style LCD
//               controller: FSM states, register map, status bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package project1_lcd_ctrl_pkg;

    // Bus-cycle sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    // Register map
    localparam logic [1:0] c_ADDR_CMD    = 2'd0;
    localparam logic [1:0] c_ADDR_DATA   = 2'd1;
    localparam logic [1:0] c_ADDR_STATUS = 2'd2;
    localparam logic [1:0] c_ADDR_CTRL   = 2'd3;

    // Status register bit positions
    localparam int c_STAT_LEVEL_LSB = 0;
    localparam int c_STAT_FULL_BIT  = 3;
    localparam int c_STAT_BUSY_BIT  = 4;
    localparam int c_STAT_OVF_BIT   = 5;

    // Control register bit positions
    localparam int c_CTRL_ON_BIT      = 0;
    localparam int c_CTRL_FLUSH_BIT   = 1;
    localparam int c_CTRL_CLR_OVF_BIT = 2;

    // Request FIFO geometry: {RS, byte}
    localparam int c_FIFO_DEPTH = 4;
    localparam int c_ENTRY_W    = 9;
    localparam int c_LEVEL_W    = 3;

    // A zero-length phase still occupies one cycle
    function automatic int eff_cyc(input int p);
        return (p < 1) ? 1 : p;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
    endfunction

endpackage
`default_nettype wire

// File: rtl/project1_lcd_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : project1_lcd_ctrl_fifo
// Description : 4-entry request FIFO with level output. A push while full is
//               accepted only when a pop frees a slot in the same cycle;
//               flush empties the FIFO and overrides a same-cycle push.
// Revision    : 1.0 - initial release
// ============================================================================
module project1_lcd_ctrl_fifo
    import project1_lcd_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    input  logic [c_ENTRY_W-1:0] din_i,
    output logic [c_LEVEL_W-1:0] level_o,
    output logic [c_ENTRY_W-1:0] head_o
);

    logic [c_ENTRY_W-1:0] mem_q [c_FIFO_DEPTH];
    logic [1:0]           rd_ptr_q;
    logic [1:0]           wr_ptr_q;
    logic [c_LEVEL_W-1:0] level_q;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_empty   = (level_q == '0);
    assign w_full    = (level_q == c_LEVEL_W'(c_FIFO_DEPTH));
    assign w_pop_ok  = pop_i && !w_empty;
    assign w_push_ok = push_i && (!w_full || w_pop_ok);

    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Storage array; the slot being vacated by a pop may be refilled on the same edge
    always_ff @(posedge clk) begin
        if (w_push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (w_pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            level_q <= level_q + c_LEVEL_W'(w_push_ok) - c_LEVEL_W'(w_pop_ok);
        end
    end

endmodule
`default_nettype wire

// File: rtl/project1_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : project1_lcd_ctrl
// Description : Avalon-MM slave driving a character LCD 8-bit parallel bus.
//               Commands/data are queued in a small FIFO and played out with
//               setup, enable pulse, hold and execution-wait phases.
// Revision    : 1.0 - initial release
// ============================================================================
module project1_lcd_ctrl
    import project1_lcd_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 12,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 82000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on
);

    localparam int c_SETUP_EFF = eff_cyc(SETUP_CYC);
    localparam int c_EN_EFF    = eff_cyc(EN_CYC);
    localparam int c_HOLD_EFF  = eff_cyc(HOLD_CYC);
    localparam int c_EXEC_EFF  = eff_cyc(EXEC_CYC);
    localparam int c_LONG_EFF  = eff_cyc(LONG_CYC);

    // One down-counter serves every phase, so it is sized for the longest one
    localparam int c_CNT_MAX = max2(max2(max2(c_SETUP_EFF, c_EN_EFF), max2(c_HOLD_EFF, c_EXEC_EFF)), c_LONG_EFF);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(c_SETUP_EFF);
    localparam logic [c_CNT_W-1:0] c_EN_LD    = c_CNT_W'(c_EN_EFF);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(c_HOLD_EFF);
    localparam logic [c_CNT_W-1:0] c_EXEC_LD  = c_CNT_W'(c_EXEC_EFF);
    localparam logic [c_CNT_W-1:0] c_LONG_LD  = c_CNT_W'(c_LONG_EFF);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_e               state_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic                 lcd_en_q;
    logic                 lcd_rs_q;
    logic [7:0]           lcd_data_q;
    logic                 lcd_on_q;
    logic                 overflow_q;

    logic                 w_wr;
    logic                 w_enq_req;
    logic                 w_ctrl_wr;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_flush;
    logic                 w_full;
    logic                 w_busy;
    logic                 w_last;
    logic [c_LEVEL_W-1:0] w_level;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_unused;

    assign w_wr      = chipselect && !write_n;
    assign w_enq_req = w_wr && (address == c_ADDR_CMD || address == c_ADDR_DATA);
    assign w_ctrl_wr = w_wr && (address == c_ADDR_CTRL);
    assign w_flush   = w_ctrl_wr && writedata[c_CTRL_FLUSH_BIT];
    assign w_pop     = (state_q == ST_IDLE) && (w_level != '0);
    assign w_full    = (w_level == c_LEVEL_W'(c_FIFO_DEPTH));
    assign w_push    = w_enq_req && (!w_full || w_pop);
    assign w_busy    = (state_q != ST_IDLE) || (w_level != '0);
    assign w_last    = (cnt_q <= c_CNT_ONE);
    assign w_unused  = ^writedata[31:8];

    project1_lcd_ctrl_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .din_i   ({address[0], writedata[7:0]}),
        .level_o (w_level),
        .head_o  (w_head)
    );

    // Control register and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_on_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                lcd_on_q <= writedata[c_CTRL_ON_BIT];
                if (writedata[c_CTRL_CLR_OVF_BIT]) begin
                    overflow_q <= 1'b0;
                end
            end
            if (w_enq_req && !w_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // LCD bus sequencer: load, setup, enable pulse, hold, execution wait
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lcd_en_q   <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_pop) begin
                        lcd_rs_q   <= w_head[8];
                        lcd_data_q <= w_head[7:0];
                        cnt_q      <= c_SETUP_LD;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_last) begin
                        lcd_en_q <= 1'b1;
                        cnt_q    <= c_EN_LD;
                        state_q  <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_q - c_CNT_ONE;
                    end
                end
                ST_PULSE: begin
                    if (w_last) begin
                        lcd_en_q <= 1'b0;
                        cnt_q    <= c_HOLD_LD;
                        state_q  <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - c_CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (w_last) begin
                        cnt_q   <= is_long_cmd(lcd_rs_q, lcd_data_q) ? c_LONG_LD : c_EXEC_LD;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q - c_CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (w_last) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - c_CNT_ONE;
                    end
                end
                default: begin
                    lcd_en_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero-wait-state register read mux
    always_comb begin
        readdata = 32'h0;
        case (address)
            c_ADDR_STATUS: begin
                readdata[c_STAT_LEVEL_LSB +: c_LEVEL_W] = w_level;
                readdata[c_STAT_FULL_BIT]               = w_full;
                readdata[c_STAT_BUSY_BIT]               = w_busy;
                readdata[c_STAT_OVF_BIT]                = overflow_q;
            end
            c_ADDR_CTRL: begin
                readdata[c_CTRL_ON_BIT] = lcd_on_q;
            end
            default: begin
                readdata = 32'h0;
            end
        endcase
    end

    assign lcd_data = lcd_data_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = lcd_en_q;
    assign lcd_on   = lcd_on_q;

endmodule
`default_nettype wire
